// File: rtl/ysyx_25030085_lsu.sv
// ysyx_25030085_lsu: single-outstanding load/store unit with alignment checks, byte strobes and wait timeout
module ysyx_25030085_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic              mem_rsp_err,
  input  logic [XLEN-1:0]   mem_rsp_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, MREQ, WAIT, RESP} state_t;

  state_t          state;
  logic            wr;
  logic [2:0]      op;
  logic [OW-1:0]   off;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   off_in;
  logic            bad_in;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] ld;

  assign req_ready = state == IDLE;

  // Request decode: misalignment/illegal-op detection and load data extraction
  always_comb begin
    off_in = req_addr[OW-1:0];
    bad_in = req_op == 3'b111 || (XLEN == 32 && (req_op == 3'b011 || req_op == 3'b110)) ||
             (req_write && req_op[2]) || |(off_in & OW'((32'd1 << req_op[1:0]) - 32'd1));
    sh     = mem_rsp_rdata >> {off, 3'b000};
    mask   = ~({XLEN{1'b1}} << (32'd8 << op[1:0]));
    ld     = (sh & mask) | ((!op[2] && |(sh & mask & ~(mask >> 1))) ? ~mask : '0);
  end

  // Transaction FSM with registered memory-side and response-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr            <= 1'b0;
      op            <= '0;
      off           <= '0;
      cnt           <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr            <= req_write;
          op            <= req_op;
          off           <= off_in;
          mem_req_write <= req_write;
          mem_req_addr  <= {req_addr[ADDR_W-1:OW], OW'(0)};
          mem_req_wdata <= req_wdata << {off_in, 3'b000};
          mem_req_wstrb <= req_write ? NB'((32'd1 << (32'd1 << req_op[1:0])) - 32'd1) << off_in : '0;
          rsp_rdata     <= '0;
          rsp_err       <= bad_in ? 2'd1 : 2'd0;
          rsp_valid     <= bad_in;
          mem_req_valid <= !bad_in;
          state         <= bad_in ? RESP : MREQ;
        end
        MREQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          cnt           <= '0;
          state         <= WAIT;
        end
        WAIT: if (mem_rsp_valid) begin
          rsp_valid <= 1'b1;
          rsp_err   <= mem_rsp_err ? 2'd2 : 2'd0;
          rsp_rdata <= (mem_rsp_err || wr) ? '0 : ld;
          state     <= RESP;
        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 2'd3;
          rsp_rdata <= '0;
          state     <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// tb_ysyx_25030085_lsu: randomized and directed checks of 32- and 64-bit LSU instances against a byte-level model
module tb_ysyx_25030085_lsu;
  logic clk = 0;
  logic rst_n = 0;
  logic sel = 0;
  logic v32 = 0, v64 = 0;
  logic req_write = 0;
  logic [2:0] req_op = 0;
  logic [31:0] req_addr = 0;
  logic [63:0] req_wdata = 0;
  logic rsp_ready = 0, mem_req_ready = 0, mem_rsp_valid = 0, mem_rsp_err = 0;
  logic [63:0] mem_rsp_rdata = 0;
  int total = 0, bad = 0;

  logic a_rdy, a_rv, a_mv, a_mw;
  logic [1:0] a_err;
  logic [31:0] a_rd, a_ma, a_mwd;
  logic [3:0] a_ms;
  logic b_rdy, b_rv, b_mv, b_mw;
  logic [1:0] b_err;
  logic [63:0] b_rd, b_mwd;
  logic [31:0] b_ma;
  logic [7:0] b_ms;

  logic o_rdy, o_rv, o_mv, o_mw;
  logic [1:0] o_err;
  logic [63:0] o_rd, o_mwd;
  logic [31:0] o_ma;
  logic [7:0] o_ms;

  always #5 clk = ~clk;

  ysyx_25030085_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) d32 (
    .clk(clk), .rst_n(rst_n), .req_valid(v32), .req_ready(a_rdy), .req_write(req_write),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .rsp_valid(a_rv),
    .rsp_ready(rsp_ready), .rsp_rdata(a_rd), .rsp_err(a_err), .mem_req_valid(a_mv),
    .mem_req_ready(mem_req_ready), .mem_req_write(a_mw), .mem_req_addr(a_ma),
    .mem_req_wdata(a_mwd), .mem_req_wstrb(a_ms), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_err(mem_rsp_err), .mem_rsp_rdata(mem_rsp_rdata[31:0]));

  ysyx_25030085_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(8)) d64 (
    .clk(clk), .rst_n(rst_n), .req_valid(v64), .req_ready(b_rdy), .req_write(req_write),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rv),
    .rsp_ready(rsp_ready), .rsp_rdata(b_rd), .rsp_err(b_err), .mem_req_valid(b_mv),
    .mem_req_ready(mem_req_ready), .mem_req_write(b_mw), .mem_req_addr(b_ma),
    .mem_req_wdata(b_mwd), .mem_req_wstrb(b_ms), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_err(mem_rsp_err), .mem_rsp_rdata(mem_rsp_rdata));

  always_comb begin
    o_rdy = sel ? b_rdy : a_rdy;
    o_rv  = sel ? b_rv : a_rv;
    o_mv  = sel ? b_mv : a_mv;
    o_mw  = sel ? b_mw : a_mw;
    o_err = sel ? b_err : a_err;
    o_rd  = sel ? b_rd : {32'b0, a_rd};
    o_mwd = sel ? b_mwd : {32'b0, a_mwd};
    o_ma  = sel ? b_ma : a_ma;
    o_ms  = sel ? b_ms : {4'b0, a_ms};
  end

  // Byte-level reference: what the memory should see and what the core should get back
  function automatic void model(input int xl, input logic w, input logic [2:0] op, input logic [31:0] addr,
                                input logic [63:0] wd, input logic [63:0] word, input logic me,
                                output logic [1:0] err, output logic [63:0] rd, output logic [31:0] ma,
                                output logic [63:0] mwd, output logic [7:0] ms);
    int nb, off, sz;
    logic ill;
    nb = xl / 8;
    off = int'(addr % nb);
    sz = 1 << op[1:0];
    ill = op == 7 || (xl == 32 && (op == 3 || op == 6)) || (w && op >= 4);
    err = (ill || off % sz != 0) ? 2'd1 : me ? 2'd2 : 2'd0;
    ma = addr - off;
    ms = 0;
    rd = 0;
    mwd = (wd << (8 * off)) & (xl == 32 ? 64'hFFFF_FFFF : {64{1'b1}});
    if (w) for (int i = 0; i < sz; i++) ms[off + i] = 1'b1;
    if (err == 0 && !w) begin
      for (int i = 0; i < sz; i++) rd[8*i +: 8] = word[8*(off+i) +: 8];
      if (op < 4 && rd[8*sz-1]) for (int i = 8 * sz; i < xl; i++) rd[i] = 1'b1;
    end
  endfunction

  task automatic start_req(input logic w, input logic [2:0] op, input logic [31:0] addr, input logic [63:0] wd);
    req_write = w; req_op = op; req_addr = addr; req_wdata = wd;
    if (sel) v64 = 1; else v32 = 1;
    total++;
    if (o_rdy !== 1'b1) begin bad++; $display("FAIL accept_ready: got %b want 1", o_rdy); end
    @(posedge clk); #1 v32 = 0; v64 = 0;
    @(negedge clk);
  endtask

  task automatic do_txn(input logic w, input logic [2:0] op, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] word, input logic me, input int ql, input int rl, input int al);
    logic [1:0] err;
    logic [63:0] rd, mwd;
    logic [31:0] ma;
    logic [7:0] ms;
    model(sel ? 64 : 32, w, op, addr, wd, word, me, err, rd, ma, mwd, ms);
    start_req(w, op, addr, wd);
    if (err == 1) begin
      total++;
      if ({o_rv, o_err, o_rd, o_mv, o_rdy} !== {1'b1, 2'd1, 64'd0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL bad_req op=%0d addr=%h: got rv=%b err=%0d rd=%h mv=%b rdy=%b want 1 1 0 0 0",
                        op, addr, o_rv, o_err, o_rd, o_mv, o_rdy);
      end
    end else begin
      mem_req_ready = 0;
      for (int c = 0; c <= ql; c++) begin
        total++;
        if ({o_mv, o_mw, o_ma, o_mwd, o_ms, o_rdy, o_rv} !== {1'b1, w, ma, mwd, ms, 1'b0, 1'b0}) begin
          bad++; $display("FAIL mem_req c=%0d: got v=%b w=%b a=%h d=%h s=%b want 1 %b %h %h %b",
                          c, o_mv, o_mw, o_ma, o_mwd, o_ms, w, ma, mwd, ms);
        end
        if (c < ql) @(negedge clk);
      end
      mem_req_ready = 1;
      @(posedge clk); #1 mem_req_ready = 0;
      @(negedge clk);
      for (int c = 0; c < rl; c++) begin
        total++;
        if ({o_mv, o_rv, o_rdy} !== 3'b000) begin
          bad++; $display("FAIL wait c=%0d: got mv=%b rv=%b rdy=%b want 000", c, o_mv, o_rv, o_rdy);
        end
        @(negedge clk);
      end
      mem_rsp_valid = 1; mem_rsp_rdata = word; mem_rsp_err = me;
      @(posedge clk); #1 mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    for (int c = 0; c <= al; c++) begin
      total++;
      if ({o_rv, o_err, o_rd, o_rdy} !== {1'b1, err, rd, 1'b0}) begin
        bad++; $display("FAIL rsp op=%0d w=%b addr=%h c=%0d: got rv=%b err=%0d rd=%h want 1 %0d %h",
                        op, w, addr, c, o_rv, o_err, o_rd, err, rd);
      end
      if (c < al) @(negedge clk);
    end
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    @(negedge clk);
    total++;
    if ({o_rv, o_rdy} !== 2'b01) begin
      bad++; $display("FAIL rsp_done: got rv=%b rdy=%b want 0 1", o_rv, o_rdy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if ({o_rdy, o_rv, o_rd, o_err, o_mv, o_mw, o_ma, o_mwd, o_ms} !== {1'b1, 1'b0, 64'd0, 2'd0, 1'b0, 1'b0, 32'd0, 64'd0, 8'd0}) begin
        bad++; $display("FAIL reset sel=%0d: got rdy=%b rv=%b rd=%h err=%0d mv=%b ma=%h want 1 0 0 0 0 0",
                        s, o_rdy, o_rv, o_rd, o_err, o_mv, o_ma);
      end
    end
    sel = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    sel = 0;
    do_txn(0, 3'b000, 32'h8000_0003, 0, 64'h80FF_1234, 0, 0, 0, 0);
    do_txn(0, 3'b100, 32'h8000_0003, 0, 64'h80FF_1234, 0, 0, 0, 0);
    do_txn(1, 3'b001, 32'h8000_0002, 64'h0000_ABCD, 0, 0, 0, 0, 0);
    do_txn(0, 3'b010, 32'h8000_0002, 0, 64'h1, 0, 0, 0, 0);
    do_txn(0, 3'b111, 32'h8000_0000, 0, 64'h1, 0, 0, 0, 0);
    do_txn(1, 3'b100, 32'h8000_0000, 64'h12, 0, 0, 0, 0, 0);
    do_txn(0, 3'b011, 32'h8000_0000, 0, 64'h1, 0, 0, 0, 0);
    do_txn(0, 3'b010, 32'h8000_0010, 0, 64'hDEAD_BEEF, 1, 0, 1, 0);
    sel = 1;
    do_txn(0, 3'b110, 32'h8000_0004, 0, 64'h8000_0001_1234_5678, 0, 0, 0, 0);
    do_txn(0, 3'b010, 32'h8000_0004, 0, 64'h8000_0001_1234_5678, 0, 0, 0, 0);
    do_txn(1, 3'b011, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0);
    do_txn(0, 3'b001, 32'h8000_0006, 0, 64'h8000_0001_1234_5678, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    sel = 0;
    do_txn(1, 3'b000, 32'h8000_0021, 64'h5A, 0, 0, 5, 2, 3);
    sel = 1;
    do_txn(0, 3'b011, 32'h8000_0040, 0, 64'hF00D_CAFE_1234_8765, 0, 5, 3, 3);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    do_txn(1, 3'b010, 32'h8000_0100, 64'hCAFE_F00D, 0, 0, 0, 0, 0);
    do_txn(0, 3'b101, 32'h8000_0102, 0, 64'hF234_5678, 0, 0, 0, 0);
    do_txn(0, 3'b010, 32'h8000_0104, 0, 64'h7777_0001, 0, 0, 3, 0);
  endtask

  task automatic test_timeout();
    sel = 0;
    start_req(0, 3'b010, 32'h8000_0200, 0);
    total++;
    if (o_mv !== 1'b1) begin bad++; $display("FAIL to_mreq: got mv=%b want 1", o_mv); end
    mem_req_ready = 1;
    @(posedge clk); #1 mem_req_ready = 0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (o_rv !== 1'b0) begin bad++; $display("FAIL to_early c=%0d: got rv=%b want 0", c, o_rv); end
      @(negedge clk);
    end
    total++;
    if ({o_rv, o_err, o_rd} !== {1'b1, 2'd3, 64'd0}) begin
      bad++; $display("FAIL to_fire: got rv=%b err=%0d rd=%h want 1 3 0", o_rv, o_err, o_rd);
    end
    mem_rsp_valid = 1; mem_rsp_rdata = 64'h1111_2222;
    @(negedge clk);
    total++;
    if ({o_rv, o_err, o_rd} !== {1'b1, 2'd3, 64'd0}) begin
      bad++; $display("FAIL to_hold: got rv=%b err=%0d rd=%h want 1 3 0", o_rv, o_err, o_rd);
    end
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    @(negedge clk); @(negedge clk);
    mem_rsp_valid = 0;
    total++;
    if ({o_rv, o_rdy, o_mv} !== 3'b010) begin
      bad++; $display("FAIL to_late: got rv=%b rdy=%b mv=%b want 0 1 0", o_rv, o_rdy, o_mv);
    end
    do_txn(0, 3'b010, 32'h8000_0204, 0, 64'h8765_4321, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    sel = 1;
    start_req(0, 3'b011, 32'h8000_0300, 0);
    mem_req_ready = 1;
    @(posedge clk); #1 mem_req_ready = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if ({o_rdy, o_rv, o_mv} !== 3'b100) begin
      bad++; $display("FAIL rst_mid: got rdy=%b rv=%b mv=%b want 1 0 0", o_rdy, o_rv, o_mv);
    end
    @(negedge clk); rst_n = 1;
    mem_rsp_valid = 1;
    @(posedge clk); #1 mem_rsp_valid = 0;
    @(negedge clk);
    total++;
    if ({o_rdy, o_rv} !== 2'b10) begin
      bad++; $display("FAIL rst_after: got rdy=%b rv=%b want 1 0", o_rdy, o_rv);
    end
    do_txn(0, 3'b100, 32'h8000_0305, 0, 64'h0000_9900_0000_0000, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [2:0] op;
      sel = n[0];
      a = $urandom;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << op[1:0]) - 1);
      do_txn(1'($urandom_range(0, 1)), op, a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, sel ? 7 : 3), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
